// File: rtl/control_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : control_sequencer_if
// Description : Bundle between the hardwired control sequencer and the
//               Datapath2 datapath.
//               master : used by the sequencer (drives strobes, OpCode, run;
//                        receives ir_op, con_ff, stop and optional step)
//               slave  : used by the datapath side (the reverse directions)
//               Optional single-step input "step" exists only when
//               CTRL_SINGLE_STEP_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
interface control_sequencer_if;
    // Status from the datapath
    logic [4:0] ir_op;
    logic       con_ff;
    logic       stop;
`ifdef CTRL_SINGLE_STEP_EN
    logic       step;
`endif
    // Bus-source enables
    logic PCout, Zlowout, Zhighout, MDRout, HIout, LOout, InPortOut, Cout, BAout, Rout;
    // Register loads
    logic PCin, MARin, MDRin, IRin, Yin, Zin, HIin, LOin, Rin, CONin, OutportIn;
    // Register-field selects
    logic Gra, Grb, Grc;
    // Memory strobes
    logic Read, Write;
    // ALU operation and activity flag
    logic [4:0] OpCode;
    logic       run;

    modport master (
`ifdef CTRL_SINGLE_STEP_EN
        input  step,
`endif
        input  ir_op, con_ff, stop,
        output PCout, Zlowout, Zhighout, MDRout, HIout, LOout, InPortOut, Cout, BAout, Rout,
        output PCin, MARin, MDRin, IRin, Yin, Zin, HIin, LOin, Rin, CONin, OutportIn,
        output Gra, Grb, Grc, Read, Write, OpCode, run
    );

    modport slave (
`ifdef CTRL_SINGLE_STEP_EN
        output step,
`endif
        output ir_op, con_ff, stop,
        input  PCout, Zlowout, Zhighout, MDRout, HIout, LOout, InPortOut, Cout, BAout, Rout,
        input  PCin, MARin, MDRin, IRin, Yin, Zin, HIin, LOin, Rin, CONin, OutportIn,
        input  Gra, Grb, Grc, Read, Write, OpCode, run
    );
endinterface
`default_nettype wire

// File: rtl/control_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : control_sequencer
// Description : Hardwired control unit for Datapath2. Steps the fetch phase
//               (T0-T2) and the per-opcode execute phase (T3-T7) selected by
//               ir_op (IR[31:27]), with con_ff gating the branch PC load.
//               Every datapath strobe and the ALU OpCode decode from the
//               state register, ir_op and con_ff.
// Ports       : clk  - clock, rising edge
//               clr  - synchronous reset, active-high
//               bus  - control_sequencer_if.master (ir_op, con_ff, stop,
//                      [step], all strobes, Read/Write, OpCode, run)
// Parameters  : MEM_WAIT - extra cycles a memory strobe is held (0..7)
//               INC_OP   - ALU OpCode for PC+1 in T0
//               ADD_OP   - ALU OpCode for address/branch-target add
// Config      : CTRL_SINGLE_STEP_EN - when defined, adds the step input and
//               pauses at every instruction boundary; one instruction runs
//               per rising edge of step.
// Revision    : 1.0 - initial release
// ============================================================================
module control_sequencer #(
    parameter int         MEM_WAIT = 0,
    parameter logic [4:0] INC_OP   = 5'd12,
    parameter logic [4:0] ADD_OP   = 5'd3
) (
    input  wire                  clk,
    input  wire                  clr,
    control_sequencer_if.master  bus
);

    // ------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------
    localparam logic [3:0] c_ST_RESET = 4'd0;
    localparam logic [3:0] c_ST_T0    = 4'd1;
    localparam logic [3:0] c_ST_T1    = 4'd2;
    localparam logic [3:0] c_ST_T2    = 4'd3;
    localparam logic [3:0] c_ST_T3    = 4'd4;
    localparam logic [3:0] c_ST_T4    = 4'd5;
    localparam logic [3:0] c_ST_T5    = 4'd6;
    localparam logic [3:0] c_ST_T6    = 4'd7;
    localparam logic [3:0] c_ST_T7    = 4'd8;
    localparam logic [3:0] c_ST_MWAIT = 4'd9;
    localparam logic [3:0] c_ST_PAUSE = 4'd10;
    localparam logic [3:0] c_ST_HALT  = 4'd11;

    // Instruction classes: opcodes sharing one execute sequence
    localparam logic [3:0] c_CL_LD     = 4'd0;
    localparam logic [3:0] c_CL_LDI    = 4'd1;
    localparam logic [3:0] c_CL_ST     = 4'd2;
    localparam logic [3:0] c_CL_RALU   = 4'd3;
    localparam logic [3:0] c_CL_IALU   = 4'd4;
    localparam logic [3:0] c_CL_MULDIV = 4'd5;
    localparam logic [3:0] c_CL_NEGNOT = 4'd6;
    localparam logic [3:0] c_CL_BR     = 4'd7;
    localparam logic [3:0] c_CL_JR     = 4'd8;
    localparam logic [3:0] c_CL_JAL    = 4'd9;
    localparam logic [3:0] c_CL_IN     = 4'd10;
    localparam logic [3:0] c_CL_OUT    = 4'd11;
    localparam logic [3:0] c_CL_MFHI   = 4'd12;
    localparam logic [3:0] c_CL_MFLO   = 4'd13;
    localparam logic [3:0] c_CL_NOP    = 4'd14;
    localparam logic [3:0] c_CL_HALT   = 4'd15;

    // Wait counter preload: MWAIT lasts MEM_WAIT cycles, counting down to 0
    localparam logic [2:0] c_WAIT_LOAD = (MEM_WAIT > 0) ? 3'(MEM_WAIT - 1) : 3'd0;

    logic [3:0] r_state;
    logic [3:0] r_wait_src;   // memory step (T1/T6/T7) that entered MWAIT
    logic [2:0] r_wait_cnt;
    logic [3:0] w_cls;
    logic [3:0] w_boundary_next;
    logic       w_pause_exit;

`ifdef CTRL_SINGLE_STEP_EN
    logic r_step_d;
    logic w_step_rise;
    assign w_step_rise = bus.step & ~r_step_d;
`endif

    // ------------------------------------------------------------------
    // Opcode to class decode
    // ------------------------------------------------------------------
    always_comb begin
        w_cls = c_CL_NOP;
        if      (bus.ir_op == 5'd0)  w_cls = c_CL_LD;
        else if (bus.ir_op == 5'd1)  w_cls = c_CL_LDI;
        else if (bus.ir_op == 5'd2)  w_cls = c_CL_ST;
        else if (bus.ir_op <= 5'd11) w_cls = c_CL_RALU;
        else if (bus.ir_op <= 5'd14) w_cls = c_CL_IALU;
        else if (bus.ir_op <= 5'd16) w_cls = c_CL_MULDIV;
        else if (bus.ir_op <= 5'd18) w_cls = c_CL_NEGNOT;
        else begin
            case (bus.ir_op)
                5'd19:   w_cls = c_CL_BR;
                5'd20:   w_cls = c_CL_JR;
                5'd21:   w_cls = c_CL_JAL;
                5'd22:   w_cls = c_CL_IN;
                5'd23:   w_cls = c_CL_OUT;
                5'd24:   w_cls = c_CL_MFHI;
                5'd25:   w_cls = c_CL_MFLO;
                5'd27:   w_cls = c_CL_HALT;
                default: w_cls = c_CL_NOP;    // 26 and 28-31
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Instruction boundary and pause-exit conditions
    // ------------------------------------------------------------------
    always_comb begin
`ifdef CTRL_SINGLE_STEP_EN
        w_boundary_next = c_ST_PAUSE;
        w_pause_exit    = w_step_rise & ~bus.stop;
`else
        w_boundary_next = bus.stop ? c_ST_PAUSE : c_ST_T0;
        w_pause_exit    = ~bus.stop;
`endif
    end

    // ------------------------------------------------------------------
    // Sequencer state
    // The T2 decision (nop/halt/execute) keys on ir_op as presented during
    // T2; from T3 on ir_op and con_ff are held by the datapath.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (clr) begin
            r_state    <= c_ST_RESET;
            r_wait_src <= c_ST_RESET;
            r_wait_cnt <= 3'd0;
`ifdef CTRL_SINGLE_STEP_EN
            r_step_d   <= 1'b0;
`endif
        end else begin
`ifdef CTRL_SINGLE_STEP_EN
            r_step_d <= bus.step;
`endif
            case (r_state)
                c_ST_RESET: r_state <= c_ST_T0;
                c_ST_T0:    r_state <= c_ST_T1;
                c_ST_T1: begin
                    if (MEM_WAIT > 0) begin
                        r_state    <= c_ST_MWAIT;
                        r_wait_src <= c_ST_T1;
                        r_wait_cnt <= c_WAIT_LOAD;
                    end else begin
                        r_state <= c_ST_T2;
                    end
                end
                c_ST_T2: begin
                    if (w_cls == c_CL_HALT)     r_state <= c_ST_HALT;
                    else if (w_cls == c_CL_NOP) r_state <= w_boundary_next;
                    else                        r_state <= c_ST_T3;
                end
                c_ST_T3: begin
                    if (w_cls == c_CL_JR  || w_cls == c_CL_IN   || w_cls == c_CL_OUT ||
                        w_cls == c_CL_MFHI || w_cls == c_CL_MFLO)
                        r_state <= w_boundary_next;
                    else
                        r_state <= c_ST_T4;
                end
                c_ST_T4: begin
                    if (w_cls == c_CL_NEGNOT || w_cls == c_CL_JAL)
                        r_state <= w_boundary_next;
                    else
                        r_state <= c_ST_T5;
                end
                c_ST_T5: begin
                    if (w_cls == c_CL_LD || w_cls == c_CL_ST ||
                        w_cls == c_CL_MULDIV || w_cls == c_CL_BR)
                        r_state <= c_ST_T6;
                    else
                        r_state <= w_boundary_next;
                end
                c_ST_T6: begin
                    if (w_cls == c_CL_LD) begin
                        if (MEM_WAIT > 0) begin
                            r_state    <= c_ST_MWAIT;
                            r_wait_src <= c_ST_T6;
                            r_wait_cnt <= c_WAIT_LOAD;
                        end else begin
                            r_state <= c_ST_T7;
                        end
                    end else if (w_cls == c_CL_ST) begin
                        r_state <= c_ST_T7;
                    end else begin
                        r_state <= w_boundary_next;
                    end
                end
                c_ST_T7: begin
                    if (w_cls == c_CL_ST && MEM_WAIT > 0) begin
                        r_state    <= c_ST_MWAIT;
                        r_wait_src <= c_ST_T7;
                        r_wait_cnt <= c_WAIT_LOAD;
                    end else begin
                        r_state <= w_boundary_next;
                    end
                end
                c_ST_MWAIT: begin
                    if (r_wait_cnt == 3'd0) begin
                        case (r_wait_src)
                            c_ST_T1: r_state <= c_ST_T2;
                            c_ST_T6: r_state <= c_ST_T7;
                            default: r_state <= w_boundary_next;  // store write done
                        endcase
                    end else begin
                        r_wait_cnt <= r_wait_cnt - 3'd1;
                    end
                end
                c_ST_PAUSE: begin
                    if (w_pause_exit) r_state <= c_ST_T0;
                end
                c_ST_HALT:  r_state <= c_ST_HALT;   // only clr leaves HALT
                default:    r_state <= c_ST_RESET;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output decode
    // ------------------------------------------------------------------
    logic w_pcout, w_zlowout, w_zhighout, w_mdrout, w_hiout, w_loout;
    logic w_inportout, w_cout, w_baout, w_rout;
    logic w_pcin, w_marin, w_mdrin, w_irin, w_yin, w_zin, w_hiin, w_loin;
    logic w_rin, w_conin, w_outportin;
    logic w_gra, w_grb, w_grc, w_read, w_write, w_run;
    logic [4:0] w_opcode;

    always_comb begin
        w_pcout = 1'b0; w_zlowout = 1'b0; w_zhighout = 1'b0; w_mdrout = 1'b0;
        w_hiout = 1'b0; w_loout = 1'b0; w_inportout = 1'b0; w_cout = 1'b0;
        w_baout = 1'b0; w_rout = 1'b0;
        w_pcin = 1'b0; w_marin = 1'b0; w_mdrin = 1'b0; w_irin = 1'b0;
        w_yin = 1'b0; w_zin = 1'b0; w_hiin = 1'b0; w_loin = 1'b0;
        w_rin = 1'b0; w_conin = 1'b0; w_outportin = 1'b0;
        w_gra = 1'b0; w_grb = 1'b0; w_grc = 1'b0;
        w_read = 1'b0; w_write = 1'b0;
        w_opcode = 5'd0;
        w_run = (r_state >= c_ST_T0) && (r_state <= c_ST_MWAIT);

        case (r_state)
            c_ST_T0: begin w_pcout = 1'b1; w_marin = 1'b1; w_zin = 1'b1; w_opcode = INC_OP; end
            c_ST_T1: begin w_zlowout = 1'b1; w_pcin = 1'b1; w_read = 1'b1; w_mdrin = 1'b1; end
            c_ST_T2: begin w_mdrout = 1'b1; w_irin = 1'b1; end
            c_ST_MWAIT: begin
                // Only the memory strobes of the step that entered the wait
                if (r_wait_src == c_ST_T7) w_write = 1'b1;
                else begin w_read = 1'b1; w_mdrin = 1'b1; end
            end
            c_ST_T3: begin
                case (w_cls)
                    c_CL_RALU, c_CL_IALU: begin w_grb = 1'b1; w_rout = 1'b1; w_yin = 1'b1; end
                    c_CL_NEGNOT: begin w_grb = 1'b1; w_rout = 1'b1; w_zin = 1'b1; w_opcode = bus.ir_op; end
                    c_CL_MULDIV: begin w_gra = 1'b1; w_rout = 1'b1; w_yin = 1'b1; end
                    c_CL_LD, c_CL_LDI, c_CL_ST: begin w_grb = 1'b1; w_baout = 1'b1; w_yin = 1'b1; end
                    c_CL_BR:   begin w_gra = 1'b1; w_rout = 1'b1; w_conin = 1'b1; end
                    c_CL_JR:   begin w_gra = 1'b1; w_rout = 1'b1; w_pcin = 1'b1; end
                    c_CL_JAL:  begin w_pcout = 1'b1; w_grb = 1'b1; w_rin = 1'b1; end
                    c_CL_IN:   begin w_inportout = 1'b1; w_gra = 1'b1; w_rin = 1'b1; end
                    c_CL_OUT:  begin w_gra = 1'b1; w_rout = 1'b1; w_outportin = 1'b1; end
                    c_CL_MFHI: begin w_hiout = 1'b1; w_gra = 1'b1; w_rin = 1'b1; end
                    c_CL_MFLO: begin w_loout = 1'b1; w_gra = 1'b1; w_rin = 1'b1; end
                    default: ;
                endcase
            end
            c_ST_T4: begin
                case (w_cls)
                    c_CL_RALU:   begin w_grc = 1'b1; w_rout = 1'b1; w_zin = 1'b1; w_opcode = bus.ir_op; end
                    c_CL_IALU:   begin w_cout = 1'b1; w_zin = 1'b1; w_opcode = bus.ir_op; end
                    c_CL_NEGNOT: begin w_zlowout = 1'b1; w_gra = 1'b1; w_rin = 1'b1; end
                    c_CL_MULDIV: begin w_grb = 1'b1; w_rout = 1'b1; w_zin = 1'b1; w_opcode = bus.ir_op; end
                    c_CL_LD, c_CL_LDI, c_CL_ST: begin w_cout = 1'b1; w_zin = 1'b1; w_opcode = ADD_OP; end
                    c_CL_BR:     begin w_pcout = 1'b1; w_yin = 1'b1; end
                    c_CL_JAL:    begin w_gra = 1'b1; w_rout = 1'b1; w_pcin = 1'b1; end
                    default: ;
                endcase
            end
            c_ST_T5: begin
                case (w_cls)
                    c_CL_RALU, c_CL_IALU, c_CL_LDI: begin w_zlowout = 1'b1; w_gra = 1'b1; w_rin = 1'b1; end
                    c_CL_MULDIV:       begin w_zlowout = 1'b1; w_loin = 1'b1; end
                    c_CL_LD, c_CL_ST:  begin w_zlowout = 1'b1; w_marin = 1'b1; end
                    c_CL_BR:           begin w_cout = 1'b1; w_zin = 1'b1; w_opcode = ADD_OP; end
                    default: ;
                endcase
            end
            c_ST_T6: begin
                case (w_cls)
                    c_CL_MULDIV: begin w_zhighout = 1'b1; w_hiin = 1'b1; end
                    c_CL_LD:     begin w_read = 1'b1; w_mdrin = 1'b1; end
                    c_CL_ST:     begin w_gra = 1'b1; w_rout = 1'b1; w_mdrin = 1'b1; end
                    c_CL_BR: begin
                        // Branch taken only when the condition flop is set
                        w_zlowout = bus.con_ff;
                        w_pcin    = bus.con_ff;
                    end
                    default: ;
                endcase
            end
            c_ST_T7: begin
                case (w_cls)
                    c_CL_LD: begin w_mdrout = 1'b1; w_gra = 1'b1; w_rin = 1'b1; end
                    c_CL_ST: w_write = 1'b1;
                    default: ;
                endcase
            end
            default: ;   // RESET, PAUSE, HALT: everything low
        endcase
    end

    assign bus.PCout     = w_pcout;
    assign bus.Zlowout   = w_zlowout;
    assign bus.Zhighout  = w_zhighout;
    assign bus.MDRout    = w_mdrout;
    assign bus.HIout     = w_hiout;
    assign bus.LOout     = w_loout;
    assign bus.InPortOut = w_inportout;
    assign bus.Cout      = w_cout;
    assign bus.BAout     = w_baout;
    assign bus.Rout      = w_rout;
    assign bus.PCin      = w_pcin;
    assign bus.MARin     = w_marin;
    assign bus.MDRin     = w_mdrin;
    assign bus.IRin      = w_irin;
    assign bus.Yin       = w_yin;
    assign bus.Zin       = w_zin;
    assign bus.HIin      = w_hiin;
    assign bus.LOin      = w_loin;
    assign bus.Rin       = w_rin;
    assign bus.CONin     = w_conin;
    assign bus.OutportIn = w_outportin;
    assign bus.Gra       = w_gra;
    assign bus.Grb       = w_grb;
    assign bus.Grc       = w_grc;
    assign bus.Read      = w_read;
    assign bus.Write     = w_write;
    assign bus.OpCode    = w_opcode;
    assign bus.run       = w_run;

endmodule
`default_nettype wire

// File: tb/tb_control_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_control_sequencer
// Description : Self-checking bench for control_sequencer (MEM_WAIT = 2).
//               Each scenario pushes the expected per-cycle control vector
//               {run, OpCode, strobes} onto a scoreboard queue and pops one
//               entry per clock, comparing against the DUT outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_control_sequencer;

    localparam int c_MW = 2;

    // Strobe bit positions in the packed vector
    localparam logic [25:0] c_PCOUT     = 26'd1 << 0;
    localparam logic [25:0] c_ZLOWOUT   = 26'd1 << 1;
    localparam logic [25:0] c_ZHIGHOUT  = 26'd1 << 2;
    localparam logic [25:0] c_MDROUT    = 26'd1 << 3;
    localparam logic [25:0] c_HIOUT     = 26'd1 << 4;
    localparam logic [25:0] c_LOOUT     = 26'd1 << 5;
    localparam logic [25:0] c_INPORTOUT = 26'd1 << 6;
    localparam logic [25:0] c_COUT      = 26'd1 << 7;
    localparam logic [25:0] c_BAOUT     = 26'd1 << 8;
    localparam logic [25:0] c_ROUT      = 26'd1 << 9;
    localparam logic [25:0] c_PCIN      = 26'd1 << 10;
    localparam logic [25:0] c_MARIN     = 26'd1 << 11;
    localparam logic [25:0] c_MDRIN     = 26'd1 << 12;
    localparam logic [25:0] c_IRIN      = 26'd1 << 13;
    localparam logic [25:0] c_YIN       = 26'd1 << 14;
    localparam logic [25:0] c_ZIN       = 26'd1 << 15;
    localparam logic [25:0] c_HIIN      = 26'd1 << 16;
    localparam logic [25:0] c_LOIN      = 26'd1 << 17;
    localparam logic [25:0] c_RIN       = 26'd1 << 18;
    localparam logic [25:0] c_CONIN     = 26'd1 << 19;
    localparam logic [25:0] c_OUTPORTIN = 26'd1 << 20;
    localparam logic [25:0] c_GRA       = 26'd1 << 21;
    localparam logic [25:0] c_GRB       = 26'd1 << 22;
    localparam logic [25:0] c_GRC       = 26'd1 << 23;
    localparam logic [25:0] c_READ      = 26'd1 << 24;
    localparam logic [25:0] c_WRITE     = 26'd1 << 25;

    logic clk;
    logic clr;
    int   checks = 0;
    int   errors = 0;
    logic [31:0] sb[$];

    control_sequencer_if bus();

    control_sequencer #(
        .MEM_WAIT (c_MW),
        .INC_OP   (5'd12),
        .ADD_OP   (5'd3)
    ) u_dut (
        .clk (clk),
        .clr (clr),
        .bus (bus.master)
    );

    wire [31:0] w_obs = {bus.run, bus.OpCode, bus.Write, bus.Read, bus.Grc, bus.Grb, bus.Gra,
                         bus.OutportIn, bus.CONin, bus.Rin, bus.LOin, bus.HIin, bus.Zin, bus.Yin,
                         bus.IRin, bus.MDRin, bus.MARin, bus.PCin, bus.Rout, bus.BAout, bus.Cout,
                         bus.InPortOut, bus.LOout, bus.HIout, bus.MDRout, bus.Zhighout,
                         bus.Zlowout, bus.PCout};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] ev(input logic [25:0] m, input logic [4:0] op);
        return {1'b1, op, m};
    endfunction

    // Pop and compare one scoreboard entry per clock until empty
    task automatic drain(input string name);
        logic [31:0] exp;
        int idx = 0;
        while (sb.size() > 0) begin
            @(posedge clk); #1;
            exp = sb.pop_front();
            checks++;
            if (w_obs !== exp) begin
                errors++;
                $display("FAIL %s cycle %0d: got %h expected %h", name, idx, w_obs, exp);
            end
            idx++;
        end
    endtask

    task automatic push_zero(input int n);
        for (int i = 0; i < n; i++) sb.push_back(32'd0);
    endtask

    task automatic push_fetch_rest();
        sb.push_back(ev(c_ZLOWOUT | c_PCIN | c_READ | c_MDRIN, 5'd0));
        for (int i = 0; i < c_MW; i++) sb.push_back(ev(c_READ | c_MDRIN, 5'd0));
        sb.push_back(ev(c_MDROUT | c_IRIN, 5'd0));
    endtask

    task automatic push_exec(input logic [4:0] op, input logic con);
        if (op == 5'd0) begin
            sb.push_back(ev(c_GRB | c_BAOUT | c_YIN, 5'd0));
            sb.push_back(ev(c_COUT | c_ZIN, 5'd3));
            sb.push_back(ev(c_ZLOWOUT | c_MARIN, 5'd0));
            for (int i = 0; i <= c_MW; i++) sb.push_back(ev(c_READ | c_MDRIN, 5'd0));
            sb.push_back(ev(c_MDROUT | c_GRA | c_RIN, 5'd0));
        end else if (op == 5'd1) begin
            sb.push_back(ev(c_GRB | c_BAOUT | c_YIN, 5'd0));
            sb.push_back(ev(c_COUT | c_ZIN, 5'd3));
            sb.push_back(ev(c_ZLOWOUT | c_GRA | c_RIN, 5'd0));
        end else if (op == 5'd2) begin
            sb.push_back(ev(c_GRB | c_BAOUT | c_YIN, 5'd0));
            sb.push_back(ev(c_COUT | c_ZIN, 5'd3));
            sb.push_back(ev(c_ZLOWOUT | c_MARIN, 5'd0));
            sb.push_back(ev(c_GRA | c_ROUT | c_MDRIN, 5'd0));
            for (int i = 0; i <= c_MW; i++) sb.push_back(ev(c_WRITE, 5'd0));
        end else if (op >= 5'd3 && op <= 5'd11) begin
            sb.push_back(ev(c_GRB | c_ROUT | c_YIN, 5'd0));
            sb.push_back(ev(c_GRC | c_ROUT | c_ZIN, op));
            sb.push_back(ev(c_ZLOWOUT | c_GRA | c_RIN, 5'd0));
        end else if (op >= 5'd12 && op <= 5'd14) begin
            sb.push_back(ev(c_GRB | c_ROUT | c_YIN, 5'd0));
            sb.push_back(ev(c_COUT | c_ZIN, op));
            sb.push_back(ev(c_ZLOWOUT | c_GRA | c_RIN, 5'd0));
        end else if (op == 5'd15 || op == 5'd16) begin
            sb.push_back(ev(c_GRA | c_ROUT | c_YIN, 5'd0));
            sb.push_back(ev(c_GRB | c_ROUT | c_ZIN, op));
            sb.push_back(ev(c_ZLOWOUT | c_LOIN, 5'd0));
            sb.push_back(ev(c_ZHIGHOUT | c_HIIN, 5'd0));
        end else if (op == 5'd17 || op == 5'd18) begin
            sb.push_back(ev(c_GRB | c_ROUT | c_ZIN, op));
            sb.push_back(ev(c_ZLOWOUT | c_GRA | c_RIN, 5'd0));
        end else if (op == 5'd19) begin
            sb.push_back(ev(c_GRA | c_ROUT | c_CONIN, 5'd0));
            sb.push_back(ev(c_PCOUT | c_YIN, 5'd0));
            sb.push_back(ev(c_COUT | c_ZIN, 5'd3));
            sb.push_back(ev(con ? (c_ZLOWOUT | c_PCIN) : 26'd0, 5'd0));
        end else if (op == 5'd20) begin
            sb.push_back(ev(c_GRA | c_ROUT | c_PCIN, 5'd0));
        end else if (op == 5'd21) begin
            sb.push_back(ev(c_PCOUT | c_GRB | c_RIN, 5'd0));
            sb.push_back(ev(c_GRA | c_ROUT | c_PCIN, 5'd0));
        end else if (op == 5'd22) begin
            sb.push_back(ev(c_INPORTOUT | c_GRA | c_RIN, 5'd0));
        end else if (op == 5'd23) begin
            sb.push_back(ev(c_GRA | c_ROUT | c_OUTPORTIN, 5'd0));
        end else if (op == 5'd24) begin
            sb.push_back(ev(c_HIOUT | c_GRA | c_RIN, 5'd0));
        end else if (op == 5'd25) begin
            sb.push_back(ev(c_LOOUT | c_GRA | c_RIN, 5'd0));
        end
        // nop / halt / 28-31: no execute cycles
    endtask

    // One full instruction starting at T0. ir_op/con_ff/stop change only once
    // T0 is showing, so the previous instruction's boundary is undisturbed.
    task automatic do_instr(input string name, input logic [4:0] op,
                            input logic con, input logic stp);
        sb.push_back(ev(c_PCOUT | c_MARIN | c_ZIN, 5'd12));
        drain(name);
        bus.ir_op  = op;
        bus.con_ff = con;
        bus.stop   = stp;
        push_fetch_rest();
        push_exec(op, con);
        drain(name);
    endtask

    task automatic test_reset();
        clr = 1'b1;
        push_zero(3);
        drain("reset");
        clr = 1'b0;
    endtask

    task automatic test_r_alu();
        do_instr("add", 5'd3, 1'b0, 1'b0);
        do_instr("sub", 5'd4, 1'b0, 1'b0);
        do_instr("ralu11", 5'd11, 1'b0, 1'b0);
    endtask

    task automatic test_i_alu();
        do_instr("addi", 5'd12, 1'b0, 1'b0);
        do_instr("ialu14", 5'd14, 1'b0, 1'b0);
        do_instr("neg", 5'd17, 1'b0, 1'b0);
        do_instr("not", 5'd18, 1'b0, 1'b0);
    endtask

    task automatic test_memory();
        do_instr("ld", 5'd0, 1'b0, 1'b0);
        do_instr("ldi", 5'd1, 1'b0, 1'b0);
        do_instr("st", 5'd2, 1'b0, 1'b0);
    endtask

    task automatic test_branch();
        do_instr("br_nt", 5'd19, 1'b0, 1'b0);
        do_instr("br_t", 5'd19, 1'b1, 1'b0);
        do_instr("jr", 5'd20, 1'b0, 1'b0);
        do_instr("jal", 5'd21, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        do_instr("in", 5'd22, 1'b0, 1'b0);
        do_instr("out", 5'd23, 1'b0, 1'b0);
        do_instr("mfhi", 5'd24, 1'b0, 1'b0);
        do_instr("mflo", 5'd25, 1'b0, 1'b0);
        do_instr("nop", 5'd26, 1'b0, 1'b0);
        do_instr("nop30", 5'd30, 1'b0, 1'b0);
        do_instr("div", 5'd16, 1'b0, 1'b0);
    endtask

    task automatic test_stop();
        do_instr("mul_stop", 5'd15, 1'b0, 1'b1);
        push_zero(5);
        drain("pause");
        bus.stop = 1'b0;
        do_instr("after_pause", 5'd3, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid();
        sb.push_back(ev(c_PCOUT | c_MARIN | c_ZIN, 5'd12));
        drain("mid_t0");
        bus.ir_op = 5'd3;
        push_fetch_rest();
        sb.push_back(ev(c_GRB | c_ROUT | c_YIN, 5'd0));
        sb.push_back(ev(c_GRC | c_ROUT | c_ZIN, 5'd3));
        drain("mid_to_t4");
        clr = 1'b1;
        push_zero(3);
        drain("mid_clr");
        clr = 1'b0;
        do_instr("mid_restart", 5'd3, 1'b0, 1'b0);
    endtask

    task automatic test_halt();
        do_instr("halt", 5'd27, 1'b0, 1'b0);
        push_zero(20);
        drain("halt_hold");
        clr = 1'b1;
        push_zero(1);
        drain("halt_clr");
        clr = 1'b0;
        do_instr("post_halt", 5'd23, 1'b0, 1'b0);
    endtask

    initial begin
        clr        = 1'b1;
        bus.ir_op  = 5'd0;
        bus.con_ff = 1'b0;
        bus.stop   = 1'b0;
`ifdef CTRL_SINGLE_STEP_EN
        bus.step   = 1'b0;
`endif
        test_reset();
        test_r_alu();
        test_i_alu();
        test_memory();
        test_branch();
        test_back_to_back();
        test_stop();
        test_reset_mid();
        test_halt();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
